// File: rtl/serial_addsub_word.sv
// serial_addsub_word
// Bit-serial adder/subtractor with word framing. Operands arrive LSB-first,
// one bit pair per accepted cycle. Each word produces a registered serial sum
// stream, the assembled parallel result, and final carry / signed-overflow
// flags. Carry is re-initialised at every start, so consecutive words are
// fully independent.
module serial_addsub_word #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             inA,
  input  logic             inB,
  input  logic             in_valid,
  output logic             sum,
  output logic             sum_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_word,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             mode;       // latched operation: 0 = add, 1 = subtract
  logic             carry;      // running carry between bit positions
  logic [CNT_W-1:0] cnt;        // index of the next bit to consume

  logic             b_eff;      // B bit after optional inversion for subtract
  logic             bit_sum;    // full-adder sum for the current bit pair
  logic             carry_nxt;  // full-adder carry for the current bit pair
  logic             take_start; // a new word begins at this edge
  logic             consume;    // a bit pair is accepted at this edge
  logic             last_bit;   // the accepted bit pair is the word's MSB

  // Full-adder slice and handshake qualifiers for the current cycle.
  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    b_eff      = inB ^ mode;
    bit_sum    = inA ^ b_eff ^ carry;
    carry_nxt  = (inA & b_eff) | (inA & carry) | (b_eff & carry);
    take_start = start && ((state == S_IDLE) || (state == S_DONE));
    consume    = (state == S_RUN) && in_valid;
    last_bit   = consume && (cnt == CNT_W'(WIDTH - 1));
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (take_start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        // A start in the DONE cycle chains straight into the next word.
        state_nxt = take_start ? S_RUN : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Serial datapath: per-word initialisation, bit consumption and the
  // final flags captured together with the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode      <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= 1'b0;
      sum_valid <= 1'b0;
      sum_word  <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // Only a consumed bit produces a fresh serial output; stalls, IDLE
      // and the start cycle all present sum_valid low.
      sum_valid <= consume;
      if (take_start) begin
        mode      <= sub;
        carry     <= sub;   // two's-complement +1 for subtract
        cnt       <= '0;
        sum_word  <= '0;
        carry_out <= 1'b0;
        overflow  <= 1'b0;
      end else if (consume) begin
        sum      <= bit_sum;
        carry    <= carry_nxt;
        sum_word <= {bit_sum, sum_word[WIDTH-1:1]};
        cnt      <= cnt + CNT_W'(1);
        if (last_bit) begin
          carry_out <= carry_nxt;
          // Signed overflow: carry into the MSB differs from carry out of it.
          overflow  <= carry ^ carry_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_word.sv
// tb_serial_addsub_word
// Directed-vector bench with a scoreboard: the driver pushes expected serial
// bits and per-word results into queues, and an independent monitor pops and
// compares them whenever the DUT presents sum_valid or done.
module tb_serial_addsub_word;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    int           lat;
    int           t0;
  } word_exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         inA = 1'b0;
  logic         inB = 1'b0;
  logic         in_valid = 1'b0;
  logic         sum;
  logic         sum_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_word;
  logic         carry_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  word_exp_t word_q[$];
  logic      bit_q[$];

  serial_addsub_word #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .inA       (inA),
    .inB       (inB),
    .in_valid  (in_valid),
    .sum       (sum),
    .sum_valid (sum_valid),
    .busy      (busy),
    .done      (done),
    .sum_word  (sum_word),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented serial bit and every completed word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sum_valid) begin
        if (bit_q.size() == 0) begin
          check("unexpected_sum_valid", 32'd1, 32'd0);
        end else begin
          logic eb;
          eb = bit_q.pop_front();
          check("sum_bit", {31'd0, sum}, {31'd0, eb});
        end
      end
      if (done) begin
        if (word_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          word_exp_t e;
          e = word_q.pop_front();
          check("sum_word", {24'd0, sum_word}, {24'd0, e.res});
          check("carry_out", {31'd0, carry_out}, {31'd0, e.c});
          check("overflow", {31'd0, overflow}, {31'd0, e.v});
          check("done_latency", cyc - e.t0, e.lat);
          check("busy_in_done", {31'd0, busy}, 32'd0);
          check("sum_valid_with_done", {31'd0, sum_valid}, 32'd1);
        end
      end
    end
  end

  // Issue one word. Calling this right after a previous word returns sets
  // start in that word's DONE cycle, giving back-to-back operation.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input logic [W-1:0] res, input logic c, input logic v,
                           input int stall_at, input int stall_len, input bit pulse_start);
    word_exp_t e;
    int        i = 0;
    int        stalls = 0;
    bit        was_stall = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    sub      = s;
    in_valid = 1'b0;
    e.res = res; e.c = c; e.v = v; e.lat = 9 + stall_len; e.t0 = cyc;
    word_q.push_back(e);
    while (i < W) begin
      @(negedge clk);
      if (was_stall) begin
        check("stall_sum_valid", {31'd0, sum_valid}, 32'd0);
        check("stall_busy", {31'd0, busy}, 32'd1);
      end
      start = pulse_start && (i == 2);
      sub   = ~s;  // mode must come only from the start cycle
      if (i == stall_at && stalls < stall_len) begin
        in_valid  = 1'b0;
        inA       = ~inA;
        inB       = ~inB;
        stalls++;
        was_stall = 1'b1;
      end else begin
        in_valid  = 1'b1;
        inA       = a[i];
        inB       = b[i];
        bit_q.push_back(res[i]);
        i++;
        was_stall = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    #3;
    check("rst_sum", {31'd0, sum}, 32'd0);
    check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum_word", {24'd0, sum_word}, 32'd0);
    check("rst_carry_out", {31'd0, carry_out}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    #20 rst_n = 1'b1;
    idle(2);

    // Basic add with continuous in_valid.
    send_word(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, -1, 0, 1'b0);
    idle(3);
    check("hold_sum_word", {24'd0, sum_word}, 32'h7F);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_sum_valid", {31'd0, sum_valid}, 32'd0);

    // Signed overflow and unsigned carry boundaries.
    send_word(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, -1, 0, 1'b0);
    idle(2);
    send_word(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1, 0, 1'b0);
    idle(2);
    send_word(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, -1, 0, 1'b0);
    idle(2);
    send_word(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, -1, 0, 1'b0);
    idle(2);

    // Stall of 3 cycles after bit 3, with a start pulse during RUN.
    send_word(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 4, 3, 1'b1);
    idle(2);

    // Back-to-back: the subtract must start its carry at 1.
    send_word(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1, 0, 1'b0);
    send_word(8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, -1, 0, 1'b0);
    idle(3);

    // Reset after 4 bits aborts the word without a done.
    @(negedge clk);
    start    = 1'b1;
    sub      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      inA      = 1'b1;
      inB      = 1'b0;
      bit_q.push_back(1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("abort_sum", {31'd0, sum}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum_word", {24'd0, sum_word}, 32'd0);
    check("abort_carry_out", {31'd0, carry_out}, 32'd0);
    check("abort_bits_drained", bit_q.size(), 32'd0);
    bit_q.delete();
    word_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3);
    check("post_reset_no_done_pending", word_q.size(), 32'd0);
    send_word(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, -1, 0, 1'b0);
    idle(4);

    check("words_outstanding", word_q.size(), 32'd0);
    check("bits_outstanding", bit_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: test did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_addsub_word.md
Name: serial_addsub_word

Overview:
- Parametrised bit-serial adder/subtractor with word framing. Operands arrive LSB-first, one bit pair per accepted cycle.
- Per word it produces:
  - the registered serial sum stream;
  - the assembled parallel result;
  - final carry/no-borrow and signed-overflow flags.
- Carry is initialised per word, so back-to-back words never leak carry. The block sits between serial-link deserialisers and the datapath accumulators.

Parameters:
- WIDTH, 8, bits per operand word (>=2).
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new word. Sampled only in IDLE or DONE.
- sub  in  1  mode, sampled with start. 0 = A+B, 1 = A-B.
- inA  in  1  serial operand A bit, LSB first.
- inB  in  1  serial operand B bit, LSB first.
- in_valid  in  1  inA/inB valid this cycle. Consumed only in RUN.
- sum  out  1  registered serial result bit.
- sum_valid  out  1  sum holds a new bit this cycle.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse: word complete.
- sum_word  out  WIDTH  assembled result. Holds until the next start.
- carry_out  out  1  final carry (add) or no-borrow (sub; 1 means A>=B unsigned). Holds until the next start.
- overflow  out  1  signed two's-complement overflow. Holds until the next start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE;
  - sum, sum_valid, busy, done, carry_out, overflow = 0;
  - sum_word = 0;
  - internal carry, mode and counter = 0.
  - Reset mid-word aborts the word. No done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches mode<=sub, carry<=sub (two's-complement +1), cnt<=0, sum_word<=0.
  - carry_out and overflow clear to 0. Next state is RUN.
  - in_valid is ignored.
- RUN (busy=1):
  - On each cycle with in_valid=1:
    - b' = inB ^ mode;
    - sum <= inA ^ b' ^ carry;
    - carry <= maj(inA, b', carry);
    - sum_word <= {new bit, sum_word[WIDTH-1:1]}, i.e. right-shift in, so bit i lands at index i after WIDTH bits;
    - sum_valid <= 1;
    - cnt increments.
  - On a cycle with in_valid=0: sum_valid <= 0. Carry, cnt and sum_word hold (stall). sum holds its last value.
  - When the consumed bit has cnt==WIDTH-1, next state is DONE. In that same edge:
    - carry_out <= new carry;
    - overflow <= carry_into_MSB ^ new carry.
  - start is ignored in RUN.
- DONE (one cycle):
  - done=1 and busy=0.
  - sum_valid=1 for the last bit, coincident with done.
  - sum_word, carry_out and overflow are final from this cycle.
  - If start=1 in DONE, take the IDLE start actions and go directly to RUN (back-to-back, zero gap). Otherwise go to IDLE.
- Latency:
  - bit i consumed at edge N appears on sum/sum_valid in the cycle after edge N;
  - done appears in the cycle after the last bit is consumed.
  - Minimum word period is WIDTH+1 cycles: start cycle + WIDTH bit cycles; DONE overlaps the next start.
- sum_valid is 0 in IDLE and on stall cycles.
- Widths: all arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- WIDTH=8, add, A=0x35, B=0x4A, in_valid continuous.
  - sum stream LSB-first = 0x7F bits, one per cycle, 1-cycle latency.
  - done 9 cycles after start.
  - sum_word=0x7F, carry_out=0, overflow=0.
- Add 0x7F+0x01 -> sum_word=0x80, carry_out=0, overflow=1. Add 0xFF+0x01 -> sum_word=0x00, carry_out=1, overflow=0.
- Sub 0x10-0x20 -> sum_word=0xF0, carry_out=0 (borrow), overflow=0. Sub 0x80-0x01 -> sum_word=0x7F, carry_out=1, overflow=1.
- Add 0x35+0x4A with in_valid low for 3 cycles after bit 3.
  - During the stall: sum_valid=0 and busy=1.
  - Result is still 0x7F. done arrives 3 cycles later than in the first test.
  - start pulsed during RUN is ignored.
- Back-to-back:
  - 0xFF+0x01 add, then 0x05-0x03 sub, with start asserted in the DONE cycle.
  - Second word runs immediately. Its carry starts at 1 (the sub init), not the leftover carry.
  - Result 0x02, carry_out=1.
- Reset mid-word:
  - assert rst_n=0 after 4 bits.
  - All outputs go 0 asynchronously and no done is issued.
  - A new word after release computes correctly, e.g. 0x12+0x34=0x46.
